// File: rtl/reg_move_sequencer_if.sv
// Command/strobe bundle between instruction decode and the register-move sequencer.
// Latency: none (wires only); the sequencer registers everything it drives.
// Backpressure: decode observes busy; a start presented while busy is dropped, not queued.
//
// Signals:
//   start, src[2:0], dst[2:0], clr : command from decode (master -> slave)
//   sel[NREG], ld[NREG]           : one-hot select / load strobes to the register file
//   busy, done                    : sequencer status back to decode
interface reg_move_sequencer_if #(
  parameter int NREG = 8
);
  logic            start;
  logic [2:0]      src;
  logic [2:0]      dst;
  logic            clr;
  logic [NREG-1:0] sel;
  logic [NREG-1:0] ld;
  logic            busy;
  logic            done;

  // Decode side issues commands and watches status.
  modport master (
    output start, src, dst, clr,
    input  sel, ld, busy, done
  );

  // Sequencer side accepts commands and drives the strobes.
  modport slave (
    input  start, src, dst, clr,
    output sel, ld, busy, done
  );
endinterface

// File: rtl/reg_move_sequencer.sv
// Sequences select/load strobes for an 8-bit register move (MOV8) or clear (CLR).
// Latency: done pulses SETTLE+LOAD_W+HOLD+1 cycles after start is sampled (NOP: 1 cycle).
// Backpressure: start is only sampled in IDLE; requests while busy are ignored, not queued.
//
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset; aborts any transfer in flight
//   bus      : reg_move_sequencer_if.slave (start/src/dst/clr in, sel/ld/busy/done out)
//   led_sel, led_ld : only with REG_MOVE_SEQ_LED_EN defined; last completed strobe patterns
//
// Optional feature macro: REG_MOVE_SEQ_LED_EN (front-panel LED latches).
//
// Register encoding: 0=A 1=B 2=C 3=D 4=M1 5=M2 6=X 7=Y.
// Ordering: select settles alone before load rises, and load drops before select falls,
// so the destination never captures a bus that is still switching.
module reg_move_sequencer #(
  parameter int SETTLE = 2,   // cycles select is held alone before load (>=1)
  parameter int LOAD_W = 2,   // cycles load overlaps select (>=1)
  parameter int HOLD   = 1,   // cycles select is held alone after load (>=1)
  parameter int NREG   = 8    // number of registers
) (
  input logic                  clk,
  input logic                  reset_n,
  reg_move_sequencer_if.slave  bus
`ifdef REG_MOVE_SEQ_LED_EN
  ,
  output logic [NREG-1:0]      led_sel,
  output logic [NREG-1:0]      led_ld
`endif
);

  // One shared phase counter, sized for the longest phase. It is loaded with
  // (phase length - 1) on state entry and the phase ends when it reaches 0.
  localparam int MAX_SL = (SETTLE > LOAD_W) ? SETTLE : LOAD_W;
  localparam int MAXP   = (MAX_SL > HOLD) ? MAX_SL : HOLD;
  localparam int CW     = (MAXP > 1) ? $clog2(MAXP) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_LOAD = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [NREG-1:0] sel_pat;   // captured select pattern (zero for CLR / NOP)
  logic [NREG-1:0] ld_pat;    // captured load pattern (zero for NOP)
  logic [NREG-1:0] sel_q;
  logic [NREG-1:0] ld_q;
  logic            busy_q;
  logic            done_q;

  function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sel_pat <= '0;
      ld_pat  <= '0;
      sel_q   <= '0;
      ld_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REG_MOVE_SEQ_LED_EN
      led_sel <= '0;
      led_ld  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (!bus.clr && (bus.src == bus.dst)) begin
              // Move onto itself: nothing to strobe, report completion next cycle.
              sel_pat <= '0;
              ld_pat  <= '0;
              done_q  <= 1'b1;
              state   <= ST_DONE;
            end else begin
              // CLR leaves the bus undriven so the destination loads zero.
              sel_pat <= bus.clr ? '0 : onehot(bus.src);
              ld_pat  <= onehot(bus.dst);
              sel_q   <= bus.clr ? '0 : onehot(bus.src);
              cnt     <= CW'(SETTLE - 1);
              state   <= ST_SEL;
            end
          end
        end

        ST_SEL: begin
          if (cnt == '0) begin
            ld_q  <= ld_pat;
            cnt   <= CW'(LOAD_W - 1);
            state <= ST_LOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_LOAD: begin
          if (cnt == '0) begin
            ld_q  <= '0;
            cnt   <= CW'(HOLD - 1);
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_HOLD: begin
          if (cnt == '0) begin
            sel_q  <= '0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
`ifdef REG_MOVE_SEQ_LED_EN
          // NOP captured zero patterns, so the LEDs clear for it.
          led_sel <= sel_pat;
          led_ld  <= ld_pat;
`endif
        end

        default: begin
          sel_q  <= '0;
          ld_q   <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sel  = sel_q;
  assign bus.ld   = ld_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/reg_move_sequencer.md
Name: reg_move_sequencer

Overview:
- Initiator side of the register-unit control bus: issues the select/load strobe sequence that makes one 8-bit register drive the data bus and another capture it.
- Covers MOV8 (register-to-register) and CLR (load zero from an undriven bus).
- Sits between instruction decode and the register file.
- Enforces the relay-style ordering: select settles before load, load drops before select.

Parameters:
- SETTLE, 2, cycles select is held alone before load rises (legal range ≥1).
- LOAD_W, 2, cycles load is asserted together with select (legal range ≥1).
- HOLD, 1, cycles select is held alone after load falls (legal range ≥1).
- NREG, 8, number of registers; fixed encoding 0=A 1=B 2=C 3=D 4=M1 5=M2 6=X 7=Y.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- src  in  3  source register index; sampled with start.
- dst  in  3  destination register index; sampled with start.
- clr  in  1  1 = clear dst (no select driven); sampled with start.
- sel  out  NREG  one-hot select strobes (selA..selY).
- ld  out  NREG  one-hot load strobes (ldA..ldY).
- busy  out  1  operation in progress.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset: asynchronous, active-low.
  - On assertion, sel=0, ld=0, busy=0, done=0 and state=IDLE immediately, including mid-operation.
  - The aborted transfer is not resumed.
- Command capture: src, dst and clr are registered when start=1 in IDLE. Input changes after that have no effect.
- States: IDLE, SEL, LOAD, HOLD, DONE.
- IDLE:
  - Outputs are all 0.
  - start=1 with clr=0 and src≠dst goes to SEL.
  - start=1 with clr=1 goes to SEL; src is ignored.
  - start=1 with clr=0 and src==dst is a NOP and goes directly to DONE, with no strobes.
- SEL:
  - Drives sel[src] (all-zero if clr) for SETTLE cycles, then goes to LOAD.
- LOAD:
  - Drives sel[src] (or none) plus ld[dst] for LOAD_W cycles, then goes to HOLD.
- HOLD:
  - Drives sel[src] (or none) with ld=0 for HOLD cycles, then goes to DONE.
- DONE:
  - sel=0, ld=0, done=1 for one cycle, then goes to IDLE.
  - A new start is accepted in the IDLE cycle that follows, not in DONE.
- busy is 1 in SEL, LOAD, HOLD and DONE, and 0 in IDLE.
- Timing: start sampled at edge k gives:
  - sel alone in cycles k+1..k+SETTLE;
  - ld in cycles k+SETTLE+1..k+SETTLE+LOAD_W;
  - done in cycle k+SETTLE+LOAD_W+HOLD+1.
  - Defaults: done at k+6.
- Invariants:
  - ld never rises or falls in the same cycle as sel.
  - At most one bit of sel and one bit of ld are ever set.
  - ld is never set while busy=0.
- start while busy: ignored, not queued.
- Phase counters: one shared down-counter, reloaded on each state entry, sized for max(SETTLE,LOAD_W,HOLD).

Optional Feature:
- Macro: REG_MOVE_SEQ_LED_EN.
- When defined:
  - Extra outputs led_sel[NREG] and led_ld[NREG] latch the sel/ld one-hot patterns of the last completed operation, updated in DONE.
  - A NOP latches zero.
  - Both reset to 0 asynchronously.
  - These drive the front-panel LEDs.
- When undefined: the ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then start=1, src=1(B), dst=0(A), clr=0 at edge 0 -> sel=8'h02 in cycles 1-5; ld=8'h01 in cycles 3-4; done=1 in cycle 6 only; busy=1 in cycles 1-6.
- start, clr=1, dst=3(D), src=5 -> sel=0 throughout; ld=8'h08 in cycles 3-4; done in cycle 6.
- start, src=dst=2, clr=0 -> no strobes; done=1 and busy=1 in cycle 1; IDLE in cycle 2.
- start pulsed again in cycles 2 and 6 with different src/dst -> ignored; the first transfer's strobes are unchanged; a start in cycle 7 is accepted.
- reset_n driven low mid-LOAD (cycle 3) -> sel, ld and busy fall to 0 without waiting for a clock edge; after release, outputs stay 0 until the next start.
- SETTLE=1, LOAD_W=3, HOLD=2 with src=7(Y), dst=4(M1) -> sel=8'h80 in cycles 1-6; ld=8'h10 in cycles 2-4; done in cycle 7. With REG_MOVE_SEQ_LED_EN: led_sel=8'h80, led_ld=8'h10 from cycle 8.
